// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM receive path: FSM state codes and the
// slot-counter width helper.
package tdm_pkg;

  localparam logic HUNT = 1'b0;
  localparam logic RUN  = 1'b1;

  // A one-bit counter is still needed when CHANNELS is 2 or less.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-CHANNELS slot counter with increment, resync load-to-1 and clear.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SW       = clog2_min1(CHANNELS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          load1,
  input  logic          clr,
  output logic [SW-1:0] count,
  output logic          last
);

  logic [SW-1:0] count_reg;
  logic [SW-1:0] count_next;

  assign last = (count_reg == SW'(CHANNELS - 1));

  // clr beats load1, which beats inc; wrap is explicit so non-power-of-2 works.
  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (load1) begin
      count_next = SW'(1);
    end else if (inc) begin
      count_next = last ? '0 : count_reg + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/tdm_demultiplexer.sv
// TDM link receiver: locks on frame_sync, collects CHANNELS slots into shadow
// registers and publishes each complete frame with a one-cycle valid pulse.
module tdm_demultiplexer
  import tdm_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            din,
  input  logic                        din_valid,
  input  logic                        frame_sync,
  output logic [CHANNELS*WIDTH-1:0]   dout,
  output logic                        dout_valid,
  output logic [$clog2(CHANNELS)-1:0] slot_idx,
  output logic                        locked,
  output logic                        sync_err
);

  localparam int SW = clog2_min1(CHANNELS);
  localparam int SHW = (CHANNELS - 1) * WIDTH;

  logic                      state_reg;
  logic                      state_next;
  logic [SW-1:0]             slot;
  logic                      slot_last;
  logic                      hunt_sync;
  logic                      misalign;
  logic                      slot_inc;
  logic                      slot_load1;
  logic                      slot_clr;
  logic                      frame_done;
  logic [SHW-1:0]            shadow_flat;
  logic [CHANNELS*WIDTH-1:0] dout_reg;
  logic                      dout_valid_reg;
  logic                      sync_err_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: once locked, only reset returns to HUNT.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HUNT:    if (din_valid && frame_sync) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = HUNT;
    endcase
  end

  // Outputs and datapath controls
  always_comb begin
    locked     = 1'b0;
    hunt_sync  = 1'b0;
    misalign   = 1'b0;
    slot_inc   = 1'b0;
    slot_load1 = 1'b0;
    slot_clr   = 1'b0;
    frame_done = 1'b0;
    case (state_reg)
      HUNT: begin
        hunt_sync  = din_valid && frame_sync;
        slot_load1 = hunt_sync;
        slot_clr   = !hunt_sync;
      end
      RUN: begin
        locked     = 1'b1;
        misalign   = din_valid && frame_sync && (slot != '0);
        slot_load1 = misalign;
        slot_inc   = din_valid && !misalign;
        frame_done = slot_inc && slot_last;
      end
      default: ;
    endcase
  end

  tdm_slot_counter #(
    .CHANNELS (CHANNELS),
    .SW       (SW)
  ) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (slot_inc),
    .load1 (slot_load1),
    .clr   (slot_clr),
    .count (slot),
    .last  (slot_last)
  );

  // The last slot never needs a shadow: it goes straight into dout with the
  // other CHANNELS-1 held samples.
  generate
    for (genvar gi = 0; gi < CHANNELS - 1; gi++) begin : g_shadow
      logic [WIDTH-1:0] sh_reg;
      logic             sh_wr;

      assign sh_wr = ((gi == 0) && slot_load1) || (slot_inc && (slot == SW'(gi)));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sh_reg <= '0;
        end else if (sh_wr) begin
          sh_reg <= din;
        end
      end

      assign shadow_flat[gi*WIDTH +: WIDTH] = sh_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
    end else begin
      dout_valid_reg <= frame_done;
      sync_err_reg   <= misalign;
      if (frame_done) begin
        dout_reg <= {din, shadow_flat};
      end
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign sync_err   = sync_err_reg;
  assign slot_idx   = slot;

endmodule
